// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, opcode map and shifter type select.
// Also used by the decoder and the pipeline control.
package alu_pkg;

    localparam int WIDTH = 32;

    typedef logic [4:0] op_t;

    localparam op_t OP_ADD   = 5'b00000;
    localparam op_t OP_SUB   = 5'b00001;
    localparam op_t OP_MULU  = 5'b00010;
    localparam op_t OP_MULS  = 5'b00011;
    localparam op_t OP_AND   = 5'b00100;
    localparam op_t OP_OR    = 5'b00101;
    localparam op_t OP_XOR   = 5'b00110;
    localparam op_t OP_NOR   = 5'b00111;
    localparam op_t OP_SLL   = 5'b01000;
    localparam op_t OP_SRL   = 5'b01001;
    localparam op_t OP_SRA   = 5'b01010;
    localparam op_t OP_SLT   = 5'b01011;
    localparam op_t OP_SLTU  = 5'b01100;
    localparam op_t OP_NOT   = 5'b01101;
    localparam op_t OP_PASSA = 5'b01110;
    localparam op_t OP_PASSB = 5'b01111;
    localparam op_t OP_ROL   = 5'b10000;
    localparam op_t OP_ROR   = 5'b10001;
    localparam op_t OP_INC   = 5'b10010;
    localparam op_t OP_DEC   = 5'b10011;

    typedef enum logic [2:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA,
        SH_ROL,
        SH_ROR
    } sh_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit. Amount 0 passes the operand through.
module alu_shifter import alu_pkg::*; #(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [SHW-1:0]   i_shamt,
    input  sh_t              i_type,
    output logic [WIDTH-1:0] o_res
);

    localparam logic [SHW:0] W_FULL = SHW'(WIDTH) == '0 ? (SHW+1)'(WIDTH) : (SHW+1)'(WIDTH);

    // Complementary amount for rotates; at amount 0 it equals WIDTH so the
    // wrapped-in term shifts out completely and the rotate returns i_a.
    logic [SHW:0]     w_inv;
    logic [WIDTH-1:0] w_sll;
    logic [WIDTH-1:0] w_srl;

    assign w_inv = W_FULL - {1'b0, i_shamt};
    assign w_sll = i_a << i_shamt;
    assign w_srl = i_a >> i_shamt;

    // Select the shift flavour
    always_comb begin
        o_res = '0;
        case (i_type)
            SH_SLL:  o_res = w_sll;
            SH_SRL:  o_res = w_srl;
            SH_SRA:  o_res = $signed(i_a) >>> i_shamt;
            SH_ROL:  o_res = w_sll | (i_a >> w_inv);
            SH_ROR:  o_res = w_srl | (i_a << w_inv);
            default: o_res = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: combinational evaluation of a/b/op, result registered
// into a 2*WIDTH output so full products and carry/borrow fit.
module alu import alu_pkg::*; #(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [4:0]         op,
    output logic [2*WIDTH-1:0] out
);

    localparam int SHW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_out;
    logic [2*WIDTH-1:0] w_next;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH:0]     w_inc;
    logic [WIDTH:0]     w_dec;
    logic [2*WIDTH-1:0] w_mulu;
    logic [2*WIDTH-1:0] w_muls;
    logic [WIDTH-1:0]   w_sh_res;
    logic               w_slt;
    logic               w_sltu;
    sh_t                w_sh_type;

    // Extra top bit of add/sub/inc/dec is carry out or borrow (a < b unsigned)
    assign w_add  = {1'b0, a} + {1'b0, b};
    assign w_sub  = {1'b0, a} - {1'b0, b};
    assign w_inc  = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
    assign w_dec  = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
    assign w_mulu = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign w_muls = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign w_slt  = $signed(a) < $signed(b);
    assign w_sltu = w_sub[WIDTH];

    // Map opcode onto the shifter's type select
    always_comb begin
        w_sh_type = SH_SLL;
        case (op)
            OP_SRL:  w_sh_type = SH_SRL;
            OP_SRA:  w_sh_type = SH_SRA;
            OP_ROL:  w_sh_type = SH_ROL;
            OP_ROR:  w_sh_type = SH_ROR;
            default: w_sh_type = SH_SLL;
        endcase
    end

    alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
        .i_a     (a),
        .i_shamt (b[SHW-1:0]),
        .i_type  (w_sh_type),
        .o_res   (w_sh_res)
    );

    // Result mux; reserved or unknown opcodes fall to default and yield 0
    always_comb begin
        w_next = '0;
        case (op)
            OP_ADD:   w_next = {{(WIDTH-1){1'b0}}, w_add};
            OP_SUB:   w_next = {{(WIDTH-1){1'b0}}, w_sub};
            OP_MULU:  w_next = w_mulu;
            OP_MULS:  w_next = w_muls;
            OP_AND:   w_next = {{WIDTH{1'b0}}, a & b};
            OP_OR:    w_next = {{WIDTH{1'b0}}, a | b};
            OP_XOR:   w_next = {{WIDTH{1'b0}}, a ^ b};
            OP_NOR:   w_next = {{WIDTH{1'b0}}, ~(a | b)};
            OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR:
                      w_next = {{WIDTH{1'b0}}, w_sh_res};
            OP_SLT:   w_next = {{(2*WIDTH-1){1'b0}}, w_slt};
            OP_SLTU:  w_next = {{(2*WIDTH-1){1'b0}}, w_sltu};
            OP_NOT:   w_next = {{WIDTH{1'b0}}, ~a};
            OP_PASSA: w_next = {{WIDTH{1'b0}}, a};
            OP_PASSB: w_next = {{WIDTH{1'b0}}, b};
            OP_INC:   w_next = {{(WIDTH-1){1'b0}}, w_inc};
            OP_DEC:   w_next = {{(WIDTH-1){1'b0}}, w_dec};
            default:  w_next = '0;
        endcase
    end

    // Capture result every edge; async reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_out <= '0;
        else        r_out <= w_next;
    end

    assign out = r_out;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: hand-computed vectors, immediate assertions.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [63:0] out;

    int checks = 0;
    int errors = 0;

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .op    (op),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] exp);
        checks++;
        assert (out === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, out, exp);
        end
    endtask

    // Drive at negedge, check one full edge later at the next negedge
    task automatic step(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic [4:0] top, input logic [63:0] exp);
        @(negedge clk);
        a = ta; b = tb_; op = top;
        @(negedge clk);
        check(tag, exp);
    endtask

    // Back-to-back vectors: new inputs every cycle
    logic [31:0] bb_a   [8];
    logic [31:0] bb_b   [8];
    logic [4:0]  bb_op  [8];
    logic [63:0] bb_exp [8];

    initial begin
        bb_a[0] = 32'h00000001; bb_b[0] = 32'h00000002; bb_op[0] = 5'b00000; bb_exp[0] = 64'h00000000_00000003;
        bb_a[1] = 32'hFFFF0000; bb_b[1] = 32'h0F0F0F0F; bb_op[1] = 5'b00110; bb_exp[1] = 64'h00000000_F0F00F0F;
        bb_a[2] = 32'hFFFFFFFF; bb_b[2] = 32'h00000000; bb_op[2] = 5'b10010; bb_exp[2] = 64'h00000001_00000000;
        bb_a[3] = 32'h00000000; bb_b[3] = 32'h00000000; bb_op[3] = 5'b10011; bb_exp[3] = 64'h00000001_FFFFFFFF;
        bb_a[4] = 32'h80000001; bb_b[4] = 32'h00000001; bb_op[4] = 5'b10000; bb_exp[4] = 64'h00000000_00000003;
        bb_a[5] = 32'h00000000; bb_b[5] = 32'h12345678; bb_op[5] = 5'b01101; bb_exp[5] = 64'h00000000_FFFFFFFF;
        bb_a[6] = 32'h11111111; bb_b[6] = 32'h12345678; bb_op[6] = 5'b01111; bb_exp[6] = 64'h00000000_12345678;
        bb_a[7] = 32'h0000FF00; bb_b[7] = 32'h000000FF; bb_op[7] = 5'b00111; bb_exp[7] = 64'h00000000_FFFF0000;

        rst_n = 1'b0; a = 32'h0; b = 32'h0; op = 5'b00000;
        #12;
        check("reset_init", 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Main function
        step("sll",        32'hF0F0F0FF, 32'h0F0F0F03, 5'b01000, 64'h00000000_878787F8);
        @(negedge clk);
        check("sll_stable", 64'h00000000_878787F8);
        step("add",        32'hF0F0F0FF, 32'h0F0F0F03, 5'b00000, 64'h00000001_00000002);
        step("sub",        32'hF0F0F0FF, 32'h0F0F0F03, 5'b00001, 64'h00000000_E1E1E1FC);
        step("and",        32'hF0F0F0FF, 32'h0F0F0F03, 5'b00100, 64'h00000000_00000003);
        step("sub_borrow", 32'h00000001, 32'h00000002, 5'b00001, 64'h00000001_FFFFFFFF);
        step("or",         32'hF0F0F0FF, 32'h0F0F0F03, 5'b00101, 64'h00000000_FFFFFFFF);
        step("mulu",       32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00010, 64'hFFFFFFFE_00000001);
        step("muls",       32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00011, 64'h00000000_00000001);
        step("muls_neg",   32'hFFFFFFFE, 32'h00000003, 5'b00011, 64'hFFFFFFFF_FFFFFFFA);
        step("sra",        32'h80000000, 32'h00000004, 5'b01010, 64'h00000000_F8000000);
        step("srl",        32'h80000000, 32'h00000004, 5'b01001, 64'h00000000_08000000);
        step("ror15",      32'hF0F0F0F0, 32'h0F0F0F0F, 5'b10001, 64'h00000000_E1E1E1E1);
        step("rol0",       32'h80000001, 32'hFFFFFFE0, 5'b10000, 64'h00000000_80000001);
        step("sll_hi_ign", 32'h00000005, 32'h00000020, 5'b01000, 64'h00000000_00000005);
        step("slt",        32'hFFFFFFFF, 32'h00000001, 5'b01011, 64'h00000000_00000001);
        step("sltu",       32'hFFFFFFFF, 32'h00000001, 5'b01100, 64'h00000000_00000000);
        step("passa",      32'hDEADBEEF, 32'h00000001, 5'b01110, 64'h00000000_DEADBEEF);
        step("reserved",   32'hDEADBEEF, 32'h00000001, 5'b11111, 64'h0);
        step("reserved14", 32'hDEADBEEF, 32'hFFFFFFFF, 5'b10100, 64'h0);

        // Back-to-back: before each edge out still holds previous result
        @(negedge clk);
        a = 32'hDEADBEEF; b = 32'h0; op = 5'b01110;
        @(posedge clk); #1;
        check("bb_pre", 64'h00000000_DEADBEEF);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("bb_hold%0d", i), (i == 0) ? 64'h00000000_DEADBEEF : bb_exp[i-1]);
            a = bb_a[i]; b = bb_b[i]; op = bb_op[i];
            @(posedge clk); #1;
            check($sformatf("bb%0d", i), bb_exp[i]);
        end

        // Async reset mid-cycle with out non-zero
        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; op = 5'b00010;
        @(posedge clk); #2;
        check("pre_reset", 64'hFFFFFFFE_00000001);
        rst_n = 1'b0;
        #1;
        check("async_reset", 64'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 32'h12345678 + i; b = 32'h0F; op = 5'(i);
            @(posedge clk); #1;
            check($sformatf("reset_hold%0d", i), 64'h0);
        end
        @(negedge clk);
        a = 32'h00000010; b = 32'h00000020; op = 5'b00000;
        rst_n = 1'b1;
        #1;
        check("release_no_edge", 64'h0);
        @(posedge clk); #1;
        check("first_capture", 64'h00000000_00000030);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
